// File: rtl/pipe_wb_unit.sv
// Write-back unit: ordered two-source result FIFO draining to regfile/PC ports.
// Define WB_FWD_EN to build the youngest-entry forwarding lookup.
module pipe_wb_unit #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [3:0]               alu_wa,
  input  logic [31:0]              alu_wd,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [3:0]               mem_wa,
  input  logic [31:0]              mem_wd,
  output logic                     we3,
  output logic [3:0]               wa3,
  output logic [31:0]              wd3,
  output logic                     pc_we,
  output logic [31:0]              pc_wd,
  output logic [15:0]              busy,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [3:0]               fwd_ra,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    slot_wa [DEPTH];
  logic [31:0]   slot_wd [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] cnt;
  logic [CW:0]   free;
  logic          pop;
  logic          mem_acc;
  logic          alu_acc;
  logic [3:0]    head_wa;

  // The head always pops when present, so its slot counts as free.
  assign pop  = (cnt != '0);
  assign free = (CW+1)'(DEPTH) - {1'b0, cnt} + {{CW{1'b0}}, pop};

  assign mem_ready = (free >= (CW+1)'(1));
  assign alu_ready = (free >= (mem_valid ? (CW+1)'(2) : (CW+1)'(1)));
  assign mem_acc   = mem_valid & mem_ready;
  assign alu_acc   = alu_valid & alu_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_wa[i] <= '0;
        slot_wd[i] <= '0;
      end
    end else begin
      if (mem_acc) begin
        slot_wa[tail] <= mem_wa;
        slot_wd[tail] <= mem_wd;
      end
      if (alu_acc) begin
        slot_wa[tail + AW'(mem_acc)] <= alu_wa;
        slot_wd[tail + AW'(mem_acc)] <= alu_wd;
      end
      tail <= tail + AW'(mem_acc) + AW'(alu_acc);
      head <= head + AW'(pop);
      cnt  <= cnt + CW'(mem_acc) + CW'(alu_acc) - CW'(pop);
    end
  end

  assign head_wa = slot_wa[head];
  assign we3     = pop && (head_wa != 4'd15);
  assign pc_we   = pop && (head_wa == 4'd15);
  assign wa3     = head_wa;
  assign wd3     = slot_wd[head];
  assign pc_wd   = slot_wd[head];
  assign count   = cnt;

  always_comb begin
    busy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < cnt) begin
        busy[slot_wa[head + AW'(k)]] = 1'b1;
      end
    end
  end

`ifdef WB_FWD_EN
  // Walk oldest to youngest so the entry nearest tail wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < cnt) && (slot_wa[head + AW'(k)] == fwd_ra)) begin
        fwd_hit  = 1'b1;
        fwd_data = slot_wd[head + AW'(k)];
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^fwd_ra;
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule
